// File: rtl/reg_view_sequencer_if.sv
// Board-facing signal bundle for the register viewer: buttons, live CPU registers,
// and the digit-decoder drive outputs.
interface reg_view_sequencer_if;
    logic        btnNext;
    logic        btnPrev;
    logic        autoEn;
    logic [7:0]  regA;
    logic [7:0]  regF;
    logic [7:0]  regB;
    logic [7:0]  regC;
    logic [7:0]  regD;
    logic [7:0]  regE;
    logic [7:0]  regH;
    logic [7:0]  regL;
    logic [15:0] regSP;
    logic [15:0] regPC;
    logic [3:0]  nameCode1;
    logic [3:0]  nameCode0;
    logic        nameBlank1;
    logic [15:0] valueOut;
    logic        valueBlankHi;
    logic        dotOut;

    modport master (
        output btnNext, btnPrev, autoEn,
        output regA, regF, regB, regC, regD, regE, regH, regL, regSP, regPC,
        input  nameCode1, nameCode0, nameBlank1, valueOut, valueBlankHi, dotOut
    );

    modport slave (
        input  btnNext, btnPrev, autoEn,
        input  regA, regF, regB, regC, regD, regE, regH, regL, regSP, regPC,
        output nameCode1, nameCode0, nameBlank1, valueOut, valueBlankHi, dotOut
    );
endinterface

// File: rtl/reg_view_sequencer.sv
// Steps the six-digit register viewer through A..L, SP, PC on debounced buttons or
// auto-scroll, holding a periodically refreshed snapshot of the selected register.
module reg_view_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REFRESH_CYCLES  = 5000000,
    parameter int AUTO_REFRESHES  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    reg_view_sequencer_if.slave  view
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int REF_W  = $clog2(REFRESH_CYCLES);
    localparam int AUTO_W = $clog2(AUTO_REFRESHES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_REFRESHES - 1);
    localparam logic [3:0]        PAGE_LAST = 4'd9;

    // Index 0 = next button, index 1 = prev button.
    logic [1:0]            btnRaw;
    logic [1:0]            sync0;
    logic [1:0]            sync1;
    logic [1:0]            stable;
    logic [1:0]            stableD;
    logic [1:0][DB_W-1:0]  dbCnt;
    logic                  nextP;
    logic                  prevP;

    logic [REF_W-1:0]      refreshCnt;
    logic                  refreshTick;
    logic [AUTO_W-1:0]     autoCnt;
    logic                  autoDue;
    logic                  clearAuto;

    logic [3:0]            page;
    logic [3:0]            pageNext;
    logic [3:0]            pageInc;
    logic [3:0]            pageDec;
    logic [15:0]           snapshot;
    logic [15:0]           selValue;
    logic                  heartbeat;

    logic [3:0]            nameHi;
    logic [3:0]            nameLo;
    logic                  narrowReg;

    assign btnRaw = {view.btnPrev, view.btnNext};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync0   <= '0;
            sync1   <= '0;
            stable  <= '0;
            stableD <= '0;
            dbCnt   <= '0;
        end else begin
            sync0   <= btnRaw;
            sync1   <= sync0;
            stableD <= stable;
            for (int i = 0; i < 2; i++) begin
                if (sync1[i] == stable[i]) begin
                    dbCnt[i] <= '0;
                end else if (dbCnt[i] == DB_LAST) begin
                    stable[i] <= sync1[i];
                    dbCnt[i]  <= '0;
                end else begin
                    dbCnt[i] <= dbCnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign nextP = stable[0] & ~stableD[0];
    assign prevP = stable[1] & ~stableD[1];

    assign refreshTick = (refreshCnt == REF_LAST);
    assign autoDue     = view.autoEn && refreshTick && (autoCnt == AUTO_LAST);
    assign pageInc     = (page == PAGE_LAST) ? 4'd0 : page + 4'd1;
    assign pageDec     = (page == 4'd0) ? PAGE_LAST : page - 4'd1;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        pageNext  = page;
        clearAuto = 1'b0;
        if (nextP && prevP) begin
            clearAuto = 1'b1;
        end else if (nextP) begin
            pageNext  = pageInc;
            clearAuto = 1'b1;
        end else if (prevP) begin
            pageNext  = pageDec;
            clearAuto = 1'b1;
        end else if (autoDue) begin
            pageNext = pageInc;
        end
    end

    // Snapshot source follows the page being entered, so a tick that coincides
    // with a page change captures the new register.
    always_comb begin
        selValue = 16'h0000;
        case (pageNext)
            4'd0:    selValue = {8'h00, view.regA};
            4'd1:    selValue = {8'h00, view.regF};
            4'd2:    selValue = {8'h00, view.regB};
            4'd3:    selValue = {8'h00, view.regC};
            4'd4:    selValue = {8'h00, view.regD};
            4'd5:    selValue = {8'h00, view.regE};
            4'd6:    selValue = {8'h00, view.regH};
            4'd7:    selValue = {8'h00, view.regL};
            4'd8:    selValue = view.regSP;
            4'd9:    selValue = view.regPC;
            default: selValue = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refreshCnt <= '0;
            autoCnt    <= '0;
            page       <= 4'd0;
            snapshot   <= 16'h0000;
            heartbeat  <= 1'b0;
        end else begin
            refreshCnt <= refreshTick ? '0 : refreshCnt + REF_W'(1);
            if (!view.autoEn || clearAuto || autoDue) begin
                autoCnt <= '0;
            end else if (refreshTick) begin
                autoCnt <= autoCnt + AUTO_W'(1);
            end
            page <= pageNext;
            if (refreshTick || (pageNext != page)) begin
                snapshot <= selValue;
            end
            if (!view.autoEn) begin
                heartbeat <= 1'b0;
            end else if (refreshTick) begin
                heartbeat <= ~heartbeat;
            end
        end
    end

    // Letter codes for pages 0-7 coincide with the page index.
    always_comb begin
        nameHi    = 4'd0;
        nameLo    = page;
        narrowReg = 1'b1;
        if (page == 4'd8) begin
            nameHi    = 4'd11;
            nameLo    = 4'd8;
            narrowReg = 1'b0;
        end else if (page == 4'd9) begin
            nameHi    = 4'd8;
            nameLo    = 4'd3;
            narrowReg = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            view.nameCode1    <= 4'd0;
            view.nameCode0    <= 4'd0;
            view.nameBlank1   <= 1'b1;
            view.valueOut     <= 16'h0000;
            view.valueBlankHi <= 1'b1;
            view.dotOut       <= 1'b1;
        end else begin
            view.nameCode1    <= nameHi;
            view.nameCode0    <= nameLo;
            view.nameBlank1   <= narrowReg;
            view.valueOut     <= snapshot;
            view.valueBlankHi <= narrowReg;
            view.dotOut       <= ~heartbeat;
        end
    end
endmodule

// File: tb/tb_reg_view_sequencer.sv
// Self-checking bench for reg_view_sequencer: directed timing scenarios plus randomized
// button/register traffic compared against a page-arithmetic reference model.
module tb_reg_view_sequencer;
    localparam int DEB  = 4;
    localparam int REF  = 8;
    localparam int AUTO = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_view_sequencer_if vif ();

    reg_view_sequencer #(
        .DEBOUNCE_CYCLES (DEB),
        .REFRESH_CYCLES  (REF),
        .AUTO_REFRESHES  (AUTO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .view  (vif)
    );

    int          passCnt  = 0;
    int          totalCnt = 0;
    int          page;
    logic [7:0]  r8 [8];
    logic [15:0] sp;
    logic [15:0] pc;
    logic [26:0] got;
    logic [26:0] want;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_regs();
        vif.regA  = r8[0];
        vif.regF  = r8[1];
        vif.regB  = r8[2];
        vif.regC  = r8[3];
        vif.regD  = r8[4];
        vif.regE  = r8[5];
        vif.regH  = r8[6];
        vif.regL  = r8[7];
        vif.regSP = sp;
        vif.regPC = pc;
    endtask

    task automatic randomize_regs();
        for (int i = 0; i < 8; i++) r8[i] = 8'($urandom);
        sp = 16'($urandom);
        pc = 16'($urandom);
        drive_regs();
    endtask

    function automatic logic [15:0] live(input int pg);
        if (pg < 8) return {8'h00, r8[pg]};
        if (pg == 8) return sp;
        return pc;
    endfunction

    // {dotOut, nameCode1, nameCode0, nameBlank1, valueBlankHi, valueOut}
    function automatic logic [26:0] expDisp(input int pg, input logic [15:0] val, input logic dot);
        logic [3:0] n1;
        logic [3:0] n0;
        logic       narrow;
        narrow = (pg < 8);
        n1 = 4'd0;
        n0 = 4'(pg);
        if (pg == 8) begin n1 = 4'd11; n0 = 4'd8; end
        if (pg == 9) begin n1 = 4'd8;  n0 = 4'd3; end
        return {dot, n1, n0, narrow, narrow, val};
    endfunction

    function automatic logic [26:0] obsDisp();
        return {vif.dotOut, vif.nameCode1, vif.nameCode0, vif.nameBlank1,
                vif.valueBlankHi, vif.valueOut};
    endfunction

    // A hold of at least DEB cycles is a press; shorter than DEB-1 is a glitch.
    task automatic press(input bit isNext, input int hold);
        if (isNext) vif.btnNext = 1'b1;
        else        vif.btnPrev = 1'b1;
        repeat (hold) tick();
        vif.btnNext = 1'b0;
        vif.btnPrev = 1'b0;
        repeat (12) tick();
        if (hold >= DEB) page = isNext ? (page + 1) % 10 : (page + 9) % 10;
    endtask

    task automatic test_reset();
        r8[0] = 8'h5A;
        drive_regs();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        page = 0;
        got = obsDisp(); want = expDisp(0, 16'h0000, 1'b1);
        totalCnt++;
        if (got !== want) $display("FAIL reset_outputs: got %h want %h", got, want);
        else passCnt++;
        repeat (REF) tick();
        got = obsDisp(); want = expDisp(0, 16'h0000, 1'b1);
        totalCnt++;
        if (got !== want) $display("FAIL reset_before_refresh: got %h want %h", got, want);
        else passCnt++;
        tick();
        got = obsDisp(); want = expDisp(0, 16'h005A, 1'b1);
        totalCnt++;
        if (got !== want) $display("FAIL reset_first_refresh: got %h want %h", got, want);
        else passCnt++;
    endtask

    task automatic test_debounce();
        vif.btnNext = 1'b1;
        repeat (2) tick();
        vif.btnNext = 1'b0;
        repeat (10) tick();
        got = obsDisp(); want = expDisp(page, live(page), 1'b1);
        totalCnt++;
        if (got !== want) $display("FAIL debounce_glitch: got %h want %h", got, want);
        else passCnt++;

        vif.btnNext = 1'b1;
        repeat (DEB + 2) tick();
        got = obsDisp(); want = expDisp(page, live(page), 1'b1);
        totalCnt++;
        if (got !== want) $display("FAIL debounce_early: got %h want %h", got, want);
        else passCnt++;
        tick();
        page = (page + 1) % 10;
        got = obsDisp(); want = expDisp(page, live(page), 1'b1);
        totalCnt++;
        if (got !== want) $display("FAIL debounce_step: got %h want %h", got, want);
        else passCnt++;
        repeat (20 - (DEB + 3)) tick();
        vif.btnNext = 1'b0;
        repeat (12) tick();
        got = obsDisp(); want = expDisp(page, live(page), 1'b1);
        totalCnt++;
        if (got !== want) $display("FAIL debounce_single_step: got %h want %h", got, want);
        else passCnt++;
    endtask

    task automatic test_wrap();
        while (page != 0) press(1'b0, 6);
        pc = 16'h0150;
        drive_regs();
        vif.btnPrev = 1'b1;
        repeat (DEB + 2) tick();
        got = obsDisp(); want = expDisp(0, live(0), 1'b1);
        totalCnt++;
        if (got !== want) $display("FAIL wrap_before: got %h want %h", got, want);
        else passCnt++;
        tick();
        page = 9;
        got = obsDisp(); want = expDisp(9, 16'h0150, 1'b1);
        totalCnt++;
        if (got !== want) $display("FAIL wrap_to_pc: got %h want %h", got, want);
        else passCnt++;
        repeat (5) tick();
        vif.btnPrev = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_sp_snapshot();
        int  waited;
        bit  seen;
        sp = 16'hFFFE;
        drive_regs();
        press(1'b0, 6);
        got = obsDisp(); want = expDisp(8, 16'hFFFE, 1'b1);
        totalCnt++;
        if (got !== want) $display("FAIL sp_page: got %h want %h", got, want);
        else passCnt++;
        sp = 16'hFFFC;
        drive_regs();
        tick();
        totalCnt++;
        if (vif.valueOut !== 16'hFFFE) $display("FAIL sp_hold: got %h want %h", vif.valueOut, 16'hFFFE);
        else passCnt++;
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < REF + 2) begin
            if (vif.valueOut !== 16'hFFFE) seen = 1'b1;
            else begin tick(); waited++; end
        end
        got = obsDisp(); want = expDisp(8, 16'hFFFC, 1'b1);
        totalCnt++;
        if (got !== want) $display("FAIL sp_refresh: got %h want %h after %0d cycles", got, want, waited);
        else passCnt++;
    endtask

    task automatic test_random();
        int op;
        int hold;
        for (int it = 0; it < 12; it++) begin
            randomize_regs();
            op = $urandom_range(0, 2);
            if (op == 2) begin
                hold = $urandom_range(1, DEB - 2);
                press($urandom_range(0, 1) == 1, hold);
            end else begin
                hold = $urandom_range(DEB, 12);
                press(op == 0, hold);
            end
            got = obsDisp(); want = expDisp(page, live(page), 1'b1);
            totalCnt++;
            if (got !== want) $display("FAIL random_step it=%0d op=%0d hold=%0d: got %h want %h", it, op, hold, got, want);
            else passCnt++;
            randomize_regs();
            repeat (REF + 2) tick();
            got = obsDisp(); want = expDisp(page, live(page), 1'b1);
            totalCnt++;
            if (got !== want) $display("FAIL random_refresh it=%0d: got %h want %h", it, got, want);
            else passCnt++;
        end
    endtask

    task automatic test_auto();
        int          changeT[$];
        int          dotT[$];
        logic [7:0]  prevName;
        logic        prevDot;
        bit          namesOk;
        bit          gapsOk;
        logic [26:0] badGot;
        logic [26:0] badWant;
        vif.autoEn = 1'b1;
        prevName = {vif.nameCode1, vif.nameCode0};
        prevDot  = vif.dotOut;
        namesOk  = 1'b1;
        badGot   = '0;
        badWant  = '0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if ({vif.nameCode1, vif.nameCode0} !== prevName) begin
                changeT.push_back(c);
                page = (page + 1) % 10;
                got = obsDisp(); want = expDisp(page, live(page), 1'b1);
                if (namesOk && got[25:0] !== want[25:0]) begin
                    namesOk = 1'b0; badGot = got; badWant = want;
                end
                prevName = {vif.nameCode1, vif.nameCode0};
            end
            if (vif.dotOut !== prevDot) begin
                dotT.push_back(c);
                prevDot = vif.dotOut;
            end
        end
        totalCnt++;
        if (!namesOk) $display("FAIL auto_pages: got %h want %h", badGot[25:0], badWant[25:0]);
        else passCnt++;
        gapsOk = (changeT.size() >= 3);
        for (int i = 1; i < changeT.size(); i++)
            if (changeT[i] - changeT[i-1] != REF * AUTO) gapsOk = 1'b0;
        totalCnt++;
        if (!gapsOk) $display("FAIL auto_period: %0d advances, want spacing %0d", changeT.size(), REF * AUTO);
        else passCnt++;
        gapsOk = (dotT.size() >= 3);
        for (int i = 1; i < dotT.size(); i++)
            if (dotT[i] - dotT[i-1] != REF) gapsOk = 1'b0;
        totalCnt++;
        if (!gapsOk) $display("FAIL dot_period: %0d toggles, want spacing %0d", dotT.size(), REF);
        else passCnt++;
    endtask

    task automatic test_both_pressed();
        logic [7:0] prevName;
        int         waited;
        bit         seen;
        prevName = {vif.nameCode1, vif.nameCode0};
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < 40) begin
            tick();
            waited++;
            if ({vif.nameCode1, vif.nameCode0} !== prevName) seen = 1'b1;
        end
        totalCnt++;
        if (!seen) $display("FAIL both_sync: no auto advance within %0d cycles", waited);
        else passCnt++;
        page = (page + 1) % 10;
        // Pulses land between two refresh ticks, so the due advance is pushed back one period.
        repeat (5) tick();
        vif.btnNext = 1'b1;
        vif.btnPrev = 1'b1;
        repeat (8) tick();
        vif.btnNext = 1'b0;
        vif.btnPrev = 1'b0;
        repeat (10) tick();
        got = obsDisp(); want = expDisp(page, live(page), 1'b1);
        totalCnt++;
        if (got[25:0] !== want[25:0]) $display("FAIL both_no_move: got %h want %h", got[25:0], want[25:0]);
        else passCnt++;
        tick();
        page = (page + 1) % 10;
        got = obsDisp(); want = expDisp(page, live(page), 1'b1);
        totalCnt++;
        if (got[25:0] !== want[25:0]) $display("FAIL both_auto_restart: got %h want %h", got[25:0], want[25:0]);
        else passCnt++;
    endtask

    task automatic test_reset_mid_scroll();
        int waited;
        waited = 0;
        while (!(vif.nameBlank1 === 1'b1 && vif.nameCode0 === 4'd5) && waited < 250) begin
            tick();
            waited++;
        end
        totalCnt++;
        if (waited >= 250) $display("FAIL scroll_reach_e: page 5 not shown within %0d cycles", waited);
        else passCnt++;
        reset = 1'b1;
        tick();
        page = 0;
        got = obsDisp(); want = expDisp(0, 16'h0000, 1'b1);
        totalCnt++;
        if (got !== want) $display("FAIL scroll_reset: got %h want %h", got, want);
        else passCnt++;
        reset = 1'b0;
        vif.autoEn = 1'b0;
        repeat (20) tick();
        got = obsDisp(); want = expDisp(0, live(0), 1'b1);
        totalCnt++;
        if (got !== want) $display("FAIL scroll_no_pending: got %h want %h", got, want);
        else passCnt++;

        vif.btnNext = 1'b1;
        repeat (DEB) tick();
        reset = 1'b1;
        vif.btnNext = 1'b0;
        tick();
        reset = 1'b0;
        repeat (15) tick();
        got = obsDisp(); want = expDisp(0, live(0), 1'b1);
        totalCnt++;
        if (got !== want) $display("FAIL debounce_reset: got %h want %h", got, want);
        else passCnt++;
    endtask

    initial begin
        reset       = 1'b1;
        vif.btnNext = 1'b0;
        vif.btnPrev = 1'b0;
        vif.autoEn  = 1'b0;
        randomize_regs();
        test_reset();
        test_debounce();
        test_wrap();
        test_sp_snapshot();
        test_random();
        test_auto();
        test_both_pressed();
        test_reset_mid_scroll();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule

// File: doc/reg_view_sequencer.md
# reg_view_sequencer

Debug-display scheduler for the CPU register viewer on the board's six 7-segment digits. It steps through the ten architectural registers (A, F, B, C, D, E, H, L, SP, PC), either on debounced push-button presses or by auto-scroll. For the selected register it drives two register-name codes, for the name-code digit decoders, and four value nibbles, for the hex digit decoders. Values are snapshotted so the display stays stable while the CPU runs.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000, cycles a synchronized button level must hold before it is accepted (≥2)
- REFRESH_CYCLES, 5000000, cycles between value-snapshot refreshes (≥2)
- AUTO_REFRESHES, 10, refresh periods between auto-advances (≥1)

Ports:
- clk  in  1  system clock, single clock domain
- reset  in  1  synchronous, active-high; one clock, and reset is synchronous and active-high
- btnNext  in  1  raw async button level, active-high, advance page
- btnPrev  in  1  raw async button level, active-high, go back a page
- autoEn  in  1  level, enables auto-scroll
- regA, regF, regB, regC, regD, regE, regH, regL  in  8 each  live CPU registers
- regSP, regPC  in  16 each  live CPU registers
- nameCode1  out  4  left name digit code
- nameCode0  out  4  right name digit code
- nameBlank1  out  1  1 = left name digit blanked
- valueOut  out  16  snapshot value; nibbles [15:12]..[3:0] drive four hex digits
- valueBlankHi  out  1  1 = upper two value digits blanked (8-bit registers)
- dotOut  out  1  heartbeat on the name digit decimal point, active-low

## Operation
- Name codes: A=0, F=1, B=2, C=3, D=4, E=5, H=6, L=7, P=8, S=11.
- Page index 0..9 = A, F, B, C, D, E, H, L, SP, PC.
- Pages 0–7: nameBlank1=1, nameCode1=0, nameCode0=letter code, valueBlankHi=1, valueOut={8'h00, reg}.
- Page 8: nameCode1=11 (S), nameCode0=8 (P).
- Page 9: nameCode1=8 (P), nameCode0=3 (C).
- Pages 8–9: nameBlank1=0, valueBlankHi=0, valueOut=16-bit reg.
- Per button, the debouncer is the same:
  - 2-FF synchronizer, then a stable-level register and a counter.
  - The counter clears whenever the synchronized level equals the stable level.
  - Otherwise it increments. On reaching DEBOUNCE_CYCLES-1 the stable level takes the synchronized level and the counter clears.
  - A 0→1 transition of the stable level produces a one-cycle step pulse (nextP / prevP).
- Page update priority, evaluated each cycle:
  - nextP and prevP both set: no move, auto counter cleared.
  - nextP only: page+1, wrapping 9→0.
  - prevP only: page-1, wrapping 0→9.
  - Any manual move clears the auto counter.
  - Else, if autoEn=1 and an auto-advance is due: page+1, wrapping.
- Refresh counter runs free 0..REFRESH_CYCLES-1; wrap gives refreshTick.
- Auto counter counts refreshTicks while autoEn=1. At AUTO_REFRESHES it is due, then clears. autoEn=0 holds it at 0.
- Snapshot is loaded from the selected live register on every refreshTick and on every page change. Otherwise it holds.
- Heartbeat flips on each refreshTick while autoEn=1. With autoEn=0 it is forced off (dotOut=1).

## Timing
- Reset values:
  - page=0, snapshot=0, all counters=0, synchronizers/stable levels=0, heartbeat off.
  - Outputs: nameCode1=0, nameCode0=0, nameBlank1=1, valueOut=0, valueBlankHi=1, dotOut=1.
- Button latency: a clean press is seen 2 cycles later by the synchronizer. The stable level rises DEBOUNCE_CYCLES-1 cycles after that.
- Step pulse to outputs:
  - The pulse is asserted in cycle N.
  - page and snapshot (from the new page's register) update at the edge ending N.
  - All outputs are registered and reflect the new page at the edge ending N+1.
- Glitches shorter than DEBOUNCE_CYCLES-1 cycles produce no pulse. Holding a button yields exactly one step.
- refreshTick coinciding with a page change: the snapshot loads from the new page.
- Auto-advance coinciding with a manual pulse: the manual pulse wins and the auto counter clears.
- Reset asserted mid-debounce or mid-scroll: everything returns to reset values on the next edge, with no pending step.

## Test plan
- Reset: assert reset 3 cycles, with regA=8'h5A -> page 0, nameCode0=0, nameBlank1=1, valueOut=0 until the first refreshTick, then 16'h005A.
- DEBOUNCE_CYCLES=4: pulse btnNext high 2 cycles -> no page change. Hold high 20 cycles -> exactly one step to F (nameCode0=1).
- Wrap: from page 0, press btnPrev once -> page 9, nameCode1=8, nameCode0=3, nameBlank1=0, valueBlankHi=0, valueOut=regPC (e.g. 16'h0150) two cycles after the pulse.
- Page 8 with regSP=16'hFFFE -> nameCode1=11, nameCode0=8, valueOut=16'hFFFE. Change regSP to 16'hFFFC -> valueOut unchanged until the next refreshTick, then 16'hFFFC.
- REFRESH_CYCLES=8, AUTO_REFRESHES=2, autoEn=1 -> page advances every 16 cycles and dotOut toggles every 8. Force nextP and prevP in the same cycle -> no move and the auto counter restarts.
- Assert reset during an auto-scroll on page 5 -> next cycle page 0, dotOut=1, counters 0.
